// File: rtl/s2p_symbol_packer.sv
// Serial-to-parallel symbol packer. Strobed serial bits are packed into SYM_W-bit symbols and queued in a DEPTH-entry FIFO.
// The macro S2P_OVF_STICKY_EN makes overflow sticky until start or reset. Without it, overflow pulses once per dropped symbol.
module s2p_symbol_packer #(
  parameter int SYM_W = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     msb_first,
  input  logic                     serial_in,
  input  logic                     data_flag,
  output logic [SYM_W-1:0]         sym_data,
  output logic                     sym_valid,
  input  logic                     sym_ready,
  output logic                     busy,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     dbg_state
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(SYM_W);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [SYM_W-1:0] sr_q, sr_d;
  logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
  logic             ord_q, ord_d;
  logic             overflow_q, overflow_d;
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [SYM_W-1:0] mem_q [DEPTH];

  logic             push, pop, drop, wr_en, full;
  logic [SYM_W-1:0] shifted;

  // Valid/ready: a symbol moves on every rising edge where sym_valid && sym_ready.
  // The head stays stable while sym_valid=1 and sym_ready=0.
  assign level     = wr_ptr_q - rd_ptr_q;
  assign full      = (level == (AW+1)'(DEPTH));
  assign sym_valid = (level != '0);
  assign sym_data  = sym_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
  assign busy      = (state_q == RUN);
  assign dbg_state = state_q;
  assign overflow  = overflow_q;
  assign shifted   = ord_q ? {sr_q[SYM_W-2:0], serial_in} : {serial_in, sr_q[SYM_W-1:1]};

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    bit_cnt_d = bit_cnt_q;
    ord_d     = ord_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    push      = 1'b0;
    pop       = sym_valid && sym_ready;
    drop      = 1'b0;
    wr_en     = 1'b0;

    if (start) begin
      // Restart flushes everything, so a pop in this cycle is irrelevant.
      state_d   = RUN;
      sr_d      = '0;
      bit_cnt_d = '0;
      ord_d     = msb_first;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      pop       = 1'b0;
    end else if (stop) begin
      state_d   = IDLE;
      sr_d      = '0;
      bit_cnt_d = '0;
    end else if (state_q == RUN && data_flag) begin
      sr_d = shifted;
      if (bit_cnt_q == CW'(SYM_W-1)) begin
        bit_cnt_d = '0;
        push      = 1'b1;
      end else begin
        bit_cnt_d = bit_cnt_q + 1'b1;
      end
    end

    if (push) begin
      if (full && !pop) drop = 1'b1;
      else wr_en = 1'b1;
    end
    if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;

`ifdef S2P_OVF_STICKY_EN
    overflow_d = overflow_q | drop;
`else
    overflow_d = drop;
`endif
    if (start) overflow_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      bit_cnt_q  <= '0;
      ord_q      <= 1'b1;
      overflow_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      bit_cnt_q  <= bit_cnt_d;
      ord_q      <= ord_d;
      overflow_q <= overflow_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage needs no reset; sym_data is masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_ptr_q[AW-1:0]] <= shifted;
  end

endmodule

// File: tb/tb_s2p_symbol_packer.sv
// Directed bench for s2p_symbol_packer with SYM_W=4 and DEPTH=4.
// Define S2P_OVF_STICKY_EN to check the sticky overflow build.
module tb_s2p_symbol_packer;

  localparam int SYM_W = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst, start, stop, msb_first, serial_in, data_flag, sym_ready;
  logic [SYM_W-1:0] sym_data;
  logic             sym_valid, busy, overflow, dbg_state;
  logic [$clog2(DEPTH):0] level;

  int checks   = 0;
  int failures = 0;
  logic [SYM_W-1:0] exp_q[$];

  s2p_symbol_packer #(.SYM_W(SYM_W), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .msb_first(msb_first),
    .serial_in(serial_in), .data_flag(data_flag), .sym_data(sym_data),
    .sym_valid(sym_valid), .sym_ready(sym_ready), .busy(busy), .level(level),
    .overflow(overflow), .dbg_state(dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic pulse_start(input logic order);
    msb_first = order;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    tick();
    stop = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    data_flag = 1'b1;
    serial_in = b;
    tick();
    data_flag = 1'b0;
  endtask

  task automatic send_sym_msb(input logic [SYM_W-1:0] v);
    for (int i = SYM_W - 1; i >= 0; i--) send_bit(v[i]);
  endtask

  // Scoreboard: pop each head symbol and compare it with the next entry of exp_q.
  task automatic drain(input string tag);
    sym_ready = 1'b1;
    while (exp_q.size() > 0) begin
      logic [SYM_W-1:0] e;
      e = exp_q.pop_front();
      check_eq({tag, "_valid"}, sym_valid, 1'b1);
      check_eq({tag, "_data"}, sym_data, e);
      tick();
    end
    check_eq({tag, "_empty"}, sym_valid, 1'b0);
    check_eq({tag, "_level0"}, level, 0);
    sym_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; stop = 1'b0; msb_first = 1'b1;
    serial_in = 1'b0; data_flag = 1'b0; sym_ready = 1'b0;
    tick(); tick();
    check_eq("rst_busy", busy, 0);
    check_eq("rst_valid", sym_valid, 0);
    check_eq("rst_data", sym_data, 0);
    check_eq("rst_level", level, 0);
    check_eq("rst_ovf", overflow, 0);
    rst = 1'b1;
    tick();

    // MSB-first 1,0,1,1 yields 0xB, visible one cycle after the last strobe.
    sym_ready = 1'b1;
    pulse_start(1'b1);
    check_eq("t1_busy", busy, 1);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    check_eq("t1_notyet", sym_valid, 0);
    send_bit(1'b1);
    check_eq("t1_valid", sym_valid, 1);
    check_eq("t1_data", sym_data, 4'hB);
    tick();
    check_eq("t1_onecycle", sym_valid, 0);

    // LSB-first yields 0xD. Changing msb_first after start has no effect.
    pulse_start(1'b0);
    msb_first = 1'b1;
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    check_eq("t2_valid", sym_valid, 1);
    check_eq("t2_data", sym_data, 4'hD);
    tick();
    check_eq("t2_onecycle", sym_valid, 0);

    // Overflow: five symbols into a four-deep FIFO with no consumer.
    sym_ready = 1'b0;
    pulse_start(1'b1);
    for (int v = 1; v <= 4; v++) send_sym_msb(SYM_W'(v));
    check_eq("t3_full_level", level, 4);
    check_eq("t3_no_ovf_yet", overflow, 0);
    send_sym_msb(4'h5);
    check_eq("t3_level", level, 4);
    check_eq("t3_ovf", overflow, 1);
    tick();
`ifdef S2P_OVF_STICKY_EN
    check_eq("t3_ovf_sticky", overflow, 1);
`else
    check_eq("t3_ovf_pulse", overflow, 0);
`endif
    exp_q.push_back(4'h1); exp_q.push_back(4'h2);
    exp_q.push_back(4'h3); exp_q.push_back(4'h4);
    drain("t3");
`ifdef S2P_OVF_STICKY_EN
    check_eq("t3_ovf_still", overflow, 1);
`endif
    pulse_start(1'b1);
    check_eq("t3_ovf_cleared", overflow, 0);

    // Full FIFO with a simultaneous pop and push: nothing is lost.
    for (int v = 6; v <= 9; v++) send_sym_msb(SYM_W'(v));
    check_eq("t4_full", level, 4);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    sym_ready = 1'b1;
    check_eq("t4_head", sym_data, 4'h6);
    send_bit(1'b0);
    sym_ready = 1'b0;
    check_eq("t4_level", level, 4);
    check_eq("t4_no_ovf", overflow, 0);
    exp_q.push_back(4'h7); exp_q.push_back(4'h8);
    exp_q.push_back(4'h9); exp_q.push_back(4'hA);
    drain("t4");

    // stop drops a partial symbol but keeps the queue. start flushes the queue.
    pulse_start(1'b1);
    send_sym_msb(4'hC);
    send_bit(1'b1); send_bit(1'b1);
    pulse_stop();
    check_eq("t5_idle", busy, 0);
    check_eq("t5_kept_level", level, 1);
    check_eq("t5_kept_data", sym_data, 4'hC);
    send_bit(1'b0);
    check_eq("t5_idle_ignored", level, 1);
    pulse_start(1'b1);
    check_eq("t5_flushed", level, 0);
    send_sym_msb(4'h5);
    exp_q.push_back(4'h5);
    drain("t5");

    // Reset in the middle of a symbol with two symbols queued.
    send_sym_msb(4'h3);
    send_sym_msb(4'hE);
    send_bit(1'b1); send_bit(1'b0);
    check_eq("t6_level2", level, 2);
    rst = 1'b0;
    data_flag = 1'b1;
    tick();
    data_flag = 1'b0;
    check_eq("t6_valid", sym_valid, 0);
    check_eq("t6_level", level, 0);
    check_eq("t6_busy", busy, 0);
    check_eq("t6_ovf", overflow, 0);
    check_eq("t6_dbg", dbg_state, 0);
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/s2p_symbol_packer.md
# s2p_symbol_packer

Parametrised serial-to-parallel converter for the transmitter front end. It collects strobed serial bits into SYM_W-bit symbols (SYM_W=4 for 16-QAM, 2 for QPSK, 6 for 64-QAM) in MSB-first or LSB-first order. Completed symbols are buffered in a DEPTH-entry FIFO and presented to the mapper over a valid/ready handshake. It replaces the fixed 4-bit converter, accepts one bit per clock, and reports overflow and FIFO level.

## Interface
- SYM_W, 4, bits per symbol; legal range 2..8.
- DEPTH, 4, output FIFO entries; power of two, at least 2.
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous, active-low reset.
- start  in  1  pulse: clear datapath, sample msb_first, enter RUN.
- stop  in  1  pulse: discard partial symbol, return to IDLE; FIFO keeps draining.
- msb_first  in  1  bit order; sampled only on an accepted start.
- serial_in  in  1  serial data bit.
- data_flag  in  1  bit strobe; serial_in is valid this cycle.
- sym_data  out  SYM_W  FIFO head symbol.
- sym_valid  out  1  FIFO not empty.
- sym_ready  in  1  consumer accepts; pop when sym_valid && sym_ready.
- busy  out  1  state == RUN.
- level  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- overflow  out  1  symbol dropped because the FIFO was full (see Configuration).

## Operation
- States: IDLE, RUN.
  - IDLE→RUN on start.
  - RUN→IDLE on stop.
  - start in RUN re-initialises and stays in RUN.
  - start and stop in the same cycle: start wins.
- Accepted start (either state) clears:
  - shift register and bit_cnt to 0;
  - FIFO pointers, so level=0 next cycle;
  - overflow.
  - It also latches ord = msb_first.
- stop clears the shift register and bit_cnt only. FIFO contents remain valid.
- In RUN, each cycle with data_flag=1 shifts serial_in:
  - ord=1: sr <= {sr[SYM_W-2:0], serial_in}, so the first bit lands in sym_data[SYM_W-1].
  - ord=0: sr <= {serial_in, sr[SYM_W-1:1]}, so the first bit lands in sym_data[0].
- bit_cnt counts 0..SYM_W-1. On the strobe with bit_cnt==SYM_W-1:
  - the completed word, including the current bit, is pushed;
  - bit_cnt wraps to 0.
- data_flag is ignored in IDLE and in the cycle start is accepted.
- Push and pop rules:
  - A push while full, with no pop in the same cycle, drops the symbol and raises overflow. The FIFO is unchanged.
  - A push and pop in the same cycle while full are both honoured; level stays DEPTH.
  - A pop while empty is ignored.
- sym_data is held stable while sym_valid=1 and sym_ready=0.
- level increments on push-only, decrements on pop-only, and is unchanged on both or neither.

## Timing
- Reset values: state=IDLE, busy=0, sym_valid=0, sym_data=0, level=0, overflow=0, bit_cnt=0, sr=0, ord=1.
- Throughput: one bit per clock, one symbol every SYM_W strobes.
- Latency from the final bit's strobe edge:
  - sym_valid=1 and sym_data correct one cycle later when the FIFO was empty;
  - otherwise behind the queued symbols.
- busy rises on the edge after start and falls on the edge after stop.
- Pop takes effect on the same edge. The next head, or sym_valid=0, is visible the following cycle.
- Reset mid-operation: all state returns to reset values on the next edge, independent of other inputs.

## Configuration
- S2P_OVF_STICKY_EN defined: overflow is sticky. It stays 1 after the first drop until start or reset.
- S2P_OVF_STICKY_EN undefined: overflow is a one-cycle pulse on the edge after each dropped symbol.

## Test plan
- SYM_W=4, start with msb_first=1, strobe bits 1,0,1,1 on consecutive cycles, sym_ready=1 → sym_data=4'hB, sym_valid high for exactly 1 cycle, 1 cycle after the last strobe.
- Same bits with msb_first=0 → sym_data=4'hD. Toggling msb_first after start does not change the order.
- sym_ready=0, strobe 5 symbols 0x1..0x5 with DEPTH=4 → level=4 and overflow set. Draining returns 0x1,0x2,0x3,0x4, and 0x5 is lost. Sticky build: overflow stays 1 until start. Non-sticky build: 1-cycle pulse.
- FIFO full, sym_ready=1 on the cycle of the 5th symbol's last strobe → no overflow, level stays 4, all 5 symbols are delivered in order.
- Two bits strobed, then stop, then start and 4 fresh bits → only the fresh symbol is emitted. Earlier queued symbols survive stop but are cleared by start.
- rst=0 asserted mid-symbol with level=2 → next cycle sym_valid=0, level=0, busy=0, overflow=0.
